// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz round controller and its scorer.
package quiz_pkg;

   localparam int unsigned SCORE_W   = 7;
   localparam int unsigned TIME_W    = 4;
   localparam int unsigned SCORE_MAX = 127;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StFetch    = 3'd1,
      StArm      = 3'd2,
      StAsk      = 3'd3,
      StJudge    = 3'd4,
      StFeedback = 3'd5,
      StDone     = 3'd6
   } qstate_t;

endpackage

// File: rtl/quiz_round_controller_if.sv
// Bundle between the round controller and the problem source, player input, timer and display.
interface quiz_round_controller_if #(
   parameter int unsigned ANS_W = 8
);
   import quiz_pkg::*;

   logic                 start;
   logic                 prob_req;
   logic                 prob_valid;
   logic [ANS_W-1:0]     prob_expected;
   logic                 ans_valid;
   logic [ANS_W-1:0]     ans_value;
   logic [TIME_W-1:0]    time_left;
   logic                 timer_reset;
   logic                 timer_stop;
   logic [2:0]           state_o;
   logic [3:0]           round_idx;
   logic [SCORE_W-1:0]   score;
   logic                 last_correct;
   logic                 last_timeout;
   logic                 done;

   // Controller side.
   modport master (
      input  start, prob_valid, prob_expected, ans_valid, ans_value, time_left,
      output prob_req, timer_reset, timer_stop, state_o, round_idx, score,
             last_correct, last_timeout, done
   );

   // Surrounding game logic side.
   modport slave (
      output start, prob_valid, prob_expected, ans_valid, ans_value, time_left,
      input  prob_req, timer_reset, timer_stop, state_o, round_idx, score,
             last_correct, last_timeout, done
   );

endinterface

// File: rtl/quiz_scorer.sv
// Registered score accumulator: adds 1 + bonus per correct answer, clamped at SCORE_MAX.
module quiz_scorer
   import quiz_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear_i,
   input  logic               add_en_i,
   input  logic [TIME_W-1:0]  bonus_i,
   output logic [SCORE_W-1:0] score_o
);

   localparam int unsigned SumW = SCORE_W + 1;

   logic [SCORE_W-1:0] score_q, score_d;
   logic [SumW-1:0]    sum;

   always_comb begin
      sum     = {1'b0, score_q} + SumW'(bonus_i) + SumW'(1);
      score_d = score_q;
      if (clear_i) begin
         score_d = '0;
      end else if (add_en_i) begin
         score_d = (sum > SumW'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         score_q <= '0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score_o = score_q;

endmodule

// File: rtl/quiz_round_controller.sv
// Game sequencer: fetch problem, arm timer, wait for answer or timeout, score, hold feedback.
module quiz_round_controller
   import quiz_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned FB_CYCLES  = 50_000_000,
   parameter int unsigned ANS_W      = 8
) (
   input logic                     clk,
   input logic                     reset,
   quiz_round_controller_if.master bus
);

   localparam int unsigned FbW = $clog2(FB_CYCLES + 1);

   qstate_t           state_q, state_d;
   logic [3:0]        round_q, round_d;
   logic [ANS_W-1:0]  exp_q, exp_d;
   logic [TIME_W-1:0] t_q, t_d;
   logic              correct_q, correct_d;
   logic              timeout_q, timeout_d;
   logic              first_q, first_d;
   logic [FbW-1:0]    fb_cnt_q, fb_cnt_d;
   logic              last_correct_q, last_correct_d;
   logic              last_timeout_q, last_timeout_d;
   logic              score_clear;
   logic              score_add;
   logic [SCORE_W-1:0] score;

   always_comb begin
      state_d        = state_q;
      round_d        = round_q;
      exp_d          = exp_q;
      t_d            = t_q;
      correct_d      = correct_q;
      timeout_d      = timeout_q;
      first_d        = first_q;
      fb_cnt_d       = fb_cnt_q;
      last_correct_d = last_correct_q;
      last_timeout_d = last_timeout_q;
      score_clear    = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               score_clear    = 1'b1;
               round_d        = '0;
               last_correct_d = 1'b0;
               last_timeout_d = 1'b0;
               state_d        = StFetch;
            end
         end
         StFetch: begin
            if (bus.prob_valid) begin
               exp_d   = bus.prob_expected;
               state_d = StArm;
            end
         end
         StArm: begin
            first_d = 1'b1;
            state_d = StAsk;
         end
         StAsk: begin
            first_d = 1'b0;
            // First ASK cycle ignores time_left: the timer output may still be stale.
            if (bus.ans_valid) begin
               t_d       = bus.time_left;
               correct_d = (bus.ans_value == exp_q);
               timeout_d = 1'b0;
               state_d   = StJudge;
            end else if (bus.time_left == '0 && !first_q) begin
               t_d       = '0;
               correct_d = 1'b0;
               timeout_d = 1'b1;
               state_d   = StJudge;
            end
         end
         StJudge: begin
            last_correct_d = correct_q;
            last_timeout_d = timeout_q;
            fb_cnt_d       = '0;
            state_d        = StFeedback;
         end
         StFeedback: begin
            if (fb_cnt_q == FbW'(FB_CYCLES - 1)) begin
               if (round_q == 4'(NUM_ROUNDS - 1)) begin
                  state_d = StDone;
               end else begin
                  round_d = round_q + 4'd1;
                  state_d = StFetch;
               end
            end else begin
               fb_cnt_d = fb_cnt_q + FbW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= StIdle;
         round_q        <= '0;
         exp_q          <= '0;
         t_q            <= '0;
         correct_q      <= 1'b0;
         timeout_q      <= 1'b0;
         first_q        <= 1'b0;
         fb_cnt_q       <= '0;
         last_correct_q <= 1'b0;
         last_timeout_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         round_q        <= round_d;
         exp_q          <= exp_d;
         t_q            <= t_d;
         correct_q      <= correct_d;
         timeout_q      <= timeout_d;
         first_q        <= first_d;
         fb_cnt_q       <= fb_cnt_d;
         last_correct_q <= last_correct_d;
         last_timeout_q <= last_timeout_d;
      end
   end

   assign score_add = (state_q == StJudge) && correct_q;

   quiz_scorer u_scorer (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (score_clear),
      .add_en_i (score_add),
      .bonus_i  (t_q),
      .score_o  (score)
   );

   assign bus.prob_req     = (state_q == StFetch);
   assign bus.timer_reset  = (state_q == StArm);
   assign bus.timer_stop   = (state_q != StAsk);
   assign bus.state_o      = state_q;
   assign bus.round_idx    = round_q;
   assign bus.score        = score;
   assign bus.last_correct = last_correct_q;
   assign bus.last_timeout = last_timeout_q;
   assign bus.done         = (state_q == StDone);

endmodule

// File: tb/tb_quiz_round_controller.sv
// Directed bench: two controllers (2 rounds and 15 rounds), scoreboard checked at each JUDGE exit.
module tb_quiz_round_controller;
   import quiz_pkg::*;

   localparam int unsigned FB = 4;

   typedef struct packed {
      logic       start;
      logic       pv;
      logic [7:0] pe;
      logic       av;
      logic [7:0] val;
      logic [3:0] tl;
   } drv_t;

   typedef struct packed {
      logic [2:0] st;
      logic       preq;
      logic       trst;
      logic       tstop;
      logic [3:0] rnd;
      logic [6:0] sc;
      logic       lc;
      logic       lt;
      logic       dn;
   } obs_t;

   typedef struct {
      int score;
      int lc;
      int lt;
      int rnd;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   drv_t dr [2];
   obs_t ob [2];
   exp_t qa [$];
   exp_t qb [$];
   int   mscore [2];
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   quiz_round_controller_if #(.ANS_W(8)) ifa ();
   quiz_round_controller_if #(.ANS_W(8)) ifb ();

   quiz_round_controller #(.NUM_ROUNDS(2), .FB_CYCLES(FB), .ANS_W(8)) dut_a (
      .clk   (clk),
      .reset (rst_n),
      .bus   (ifa)
   );

   quiz_round_controller #(.NUM_ROUNDS(15), .FB_CYCLES(FB), .ANS_W(8)) dut_b (
      .clk   (clk),
      .reset (rst_n),
      .bus   (ifb)
   );

   assign {ifa.start, ifa.prob_valid, ifa.prob_expected, ifa.ans_valid, ifa.ans_value,
           ifa.time_left} = dr[0];
   assign {ifb.start, ifb.prob_valid, ifb.prob_expected, ifb.ans_valid, ifb.ans_value,
           ifb.time_left} = dr[1];
   assign ob[0] = {ifa.state_o, ifa.prob_req, ifa.timer_reset, ifa.timer_stop, ifa.round_idx,
                   ifa.score, ifa.last_correct, ifa.last_timeout, ifa.done};
   assign ob[1] = {ifb.state_o, ifb.prob_req, ifb.timer_reset, ifb.timer_stop, ifb.round_idx,
                   ifb.score, ifb.last_correct, ifb.last_timeout, ifb.done};

   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_st(int w, logic [2:0] st, string name);
      for (int i = 0; i < 200; i++) begin
         if (ob[w].st == st) return;
         tick();
      end
      total++;
      bad++;
      $display("FAIL %s: state %0d never reached, last state %0d", name, st, ob[w].st);
   endtask

   task automatic push(int w, int lc, int lt, int rnd);
      exp_t e;
      e.score = mscore[w];
      e.lc    = lc;
      e.lt    = lt;
      e.rnd   = rnd;
      if (w == 0) qa.push_back(e);
      else        qb.push_back(e);
   endtask

   task automatic start_game(int w);
      dr[w].start = 1'b1;
      tick();
      dr[w].start = 1'b0;
      mscore[w]   = 0;
      chk("start->prob_req", int'(ob[w].preq), 1);
   endtask

   // mode 0: answer in first ASK cycle; 1: timeout; 2: grace then answer at time_left=0;
   // 3: start pulse then reset while in ASK.
   task automatic play_round(int w, logic [7:0] pexp, logic [7:0] ans, int tl, int mode,
                             bit stall, int rnd);
      int sum;
      wait_st(w, 3'd1, "reach fetch");
      if (stall) begin
         dr[w].av    = 1'b1;
         dr[w].val   = ans;
         dr[w].start = 1'b1;
         tick();
         dr[w].av    = 1'b0;
         dr[w].start = 1'b0;
         chk("fetch ignores ans/start", int'(ob[w].st), 1);
         chk("prob_req held", int'(ob[w].preq), 1);
      end
      dr[w].pv = 1'b1;
      dr[w].pe = pexp;
      dr[w].tl = 4'd0;
      tick();
      dr[w].pv = 1'b0;
      chk("prob_valid->arm", int'(ob[w].st), 2);
      chk("timer_reset in arm", int'(ob[w].trst), 1);
      tick();
      chk("timer_stop low in ask", int'(ob[w].tstop), 0);
      case (mode)
         0: begin
            dr[w].tl  = 4'(tl);
            dr[w].av  = 1'b1;
            dr[w].val = ans;
            if (ans == pexp) begin
               sum = mscore[w] + 1 + tl;
               mscore[w] = (sum > 127) ? 127 : sum;
               push(w, 1, 0, rnd);
            end else begin
               push(w, 0, 0, rnd);
            end
            tick();
            dr[w].av = 1'b0;
         end
         1: begin
            dr[w].tl = 4'd3;
            tick();
            chk("ask holds before timeout", int'(ob[w].st), 3);
            dr[w].tl = 4'd0;
            push(w, 0, 1, rnd);
            tick();
         end
         2: begin
            tick();
            chk("grace cycle no timeout", int'(ob[w].st), 3);
            dr[w].av  = 1'b1;
            dr[w].val = ans;
            mscore[w] = mscore[w] + 1;
            push(w, 1, 0, rnd);
            tick();
            dr[w].av = 1'b0;
         end
         default: begin
            dr[w].tl    = 4'd5;
            dr[w].start = 1'b1;
            tick();
            dr[w].start = 1'b0;
            chk("start ignored in ask", int'(ob[w].st), 3);
            rst_n = 1'b0;
            tick();
            rst_n     = 1'b1;
            mscore[w] = 0;
            chk("reset in ask -> idle", int'(ob[w].st), 0);
            chk("reset timer_stop", int'(ob[w].tstop), 1);
            chk("reset score", int'(ob[w].sc), 0);
            chk("reset round_idx", int'(ob[w].rnd), 0);
            chk("reset last_correct", int'(ob[w].lc), 0);
         end
      endcase
      dr[w].tl = 4'd9;
   endtask

   // Scoreboard monitor: pops one expectation at each JUDGE->FEEDBACK transition.
   logic [2:0] prev_st [2] = '{3'd0, 3'd0};
   int         fb_n [2]     = '{0, 0};
   int         last_rnd [2] = '{0, 0};

   task automatic mon_step(int w);
      exp_t e;
      bit   have;
      have = 1'b0;
      if (ob[w].st == 3'd5 && prev_st[w] == 3'd4) begin
         if (w == 0 && qa.size() > 0) begin
            e = qa.pop_front();
            have = 1'b1;
         end else if (w == 1 && qb.size() > 0) begin
            e = qb.pop_front();
            have = 1'b1;
         end
         if (have) begin
            chk("judge score", int'(ob[w].sc), e.score);
            chk("judge last_correct", int'(ob[w].lc), e.lc);
            chk("judge last_timeout", int'(ob[w].lt), e.lt);
            chk("judge round_idx", int'(ob[w].rnd), e.rnd);
            last_rnd[w] = e.rnd;
         end else begin
            total++;
            bad++;
            $display("FAIL unexpected judge on dut %0d: score %0d", w, ob[w].sc);
         end
         fb_n[w] = 0;
      end
      if (ob[w].st == 3'd5) begin
         fb_n[w]++;
      end else if (prev_st[w] == 3'd5) begin
         chk("feedback length", fb_n[w], FB);
         if (ob[w].st == 3'd1) chk("round advance", int'(ob[w].rnd), last_rnd[w] + 1);
      end
      prev_st[w] = ob[w].st;
   endtask

   always @(negedge clk) begin
      for (int w = 0; w < 2; w++) mon_step(w);
   end

   initial begin
      rst_n = 1'b0;
      for (int w = 0; w < 2; w++) begin
         dr[w]     = '0;
         dr[w].tl  = 4'd9;
         mscore[w] = 0;
      end
      tick();
      tick();
      chk("reset state", int'(ob[0].st), 0);
      chk("reset prob_req", int'(ob[0].preq), 0);
      chk("reset timer_reset", int'(ob[0].trst), 0);
      chk("reset timer_stop", int'(ob[0].tstop), 1);
      chk("reset score", int'(ob[0].sc), 0);
      chk("reset round", int'(ob[0].rnd), 0);
      chk("reset flags", int'({ob[0].lc, ob[0].lt}), 0);
      chk("reset done", int'(ob[0].dn), 0);
      rst_n = 1'b1;
      tick();

      // Game 1: correct at time_left=6, then timeout.
      start_game(0);
      play_round(0, 8'h2A, 8'h2A, 6, 0, 1'b0, 0);
      play_round(0, 8'h33, 8'h00, 0, 1, 1'b0, 1);
      wait_st(0, 3'd6, "game1 done");
      chk("game1 done", int'(ob[0].dn), 1);
      chk("game1 score", int'(ob[0].sc), 7);
      chk("game1 last_timeout", int'(ob[0].lt), 1);

      // Game 2 from DONE: wrong answer, then grace + coincident answer.
      start_game(0);
      play_round(0, 8'h2A, 8'h2B, 5, 0, 1'b0, 0);
      play_round(0, 8'h11, 8'h11, 0, 2, 1'b1, 1);
      wait_st(0, 3'd6, "game2 done");
      chk("game2 score", int'(ob[0].sc), 1);
      chk("game2 last_correct", int'(ob[0].lc), 1);
      chk("game2 last_timeout", int'(ob[0].lt), 0);

      // Game 3: score 10, then reset mid-ASK.
      start_game(0);
      play_round(0, 8'h2A, 8'h2A, 9, 0, 1'b0, 0);
      play_round(0, 8'h05, 8'h05, 5, 3, 1'b0, 1);
      tick();
      tick();
      chk("idle after reset", int'(ob[0].st), 0);

      // Saturation on the 15-round instance: +10 per round, clamps at 127.
      start_game(1);
      for (int r = 0; r < 15; r++) begin
         play_round(1, 8'(r + 1), 8'(r + 1), 9, 0, 1'b0, r);
      end
      wait_st(1, 3'd6, "sat done");
      chk("sat score", int'(ob[1].sc), 127);
      chk("sat done", int'(ob[1].dn), 1);

      tick();
      tick();
      chk("scoreboard A drained", qa.size(), 0);
      chk("scoreboard B drained", qb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/quiz_round_controller.md
# quiz_round_controller

Sequencer for one game of the speed mental-conversion quiz. It fetches a problem from the random problem source and arms the existing per-question countdown timer. It then waits for the player's answer or a timeout, scores the result, holds a feedback interval, and repeats for a fixed number of rounds. It sits between the problem generator, the player input debouncer/encoder, the countdown timer and the display/score logic.

## Interface
- NUM_ROUNDS, 10: questions per game (1..15)
- FB_CYCLES, 50_000_000: feedback hold length in clk cycles (≥1)
- ANS_W, 8: width of answer and expected value
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; starts a game from IDLE or DONE
- prob_req  out  ANS_W-independent 1  request for a new problem; held until prob_valid
- prob_valid  in  1  problem source has the expected answer on prob_expected
- prob_expected  in  ANS_W  correct answer for the current problem
- ans_valid  in  1  one-cycle pulse; player submitted ans_value
- ans_value  in  ANS_W  player answer
- time_left  in  4  countdown timer output (9..0)
- timer_reset  out  1  active-high reload pulse to countdown timer
- timer_stop  out  1  freezes countdown timer
- state_o  out  3  current state encoding
- round_idx  out  4  current round, 0-based
- score  out  7  accumulated score, saturating
- last_correct  out  1  previous round answered correctly
- last_timeout  out  1  previous round timed out
- done  out  1  game finished

## Operation
- States: IDLE=0, FETCH=1, ARM=2, ASK=3, JUDGE=4, FEEDBACK=5, DONE=6. 7 is unreachable and recovers to IDLE next cycle.
- IDLE: when start=1, clear score, round_idx, last_correct and last_timeout, then go to FETCH.
- FETCH: prob_req=1. On prob_valid=1, capture prob_expected into exp_r, then go to ARM. Other inputs are ignored.
- ARM: exactly 1 cycle with timer_reset=1, then go to ASK.
- ASK: timer_stop=0.
  - ans_valid=1: capture t_r=time_left, set correct_r=(ans_value==exp_r), go to JUDGE.
  - Otherwise, if time_left==0 and this is not the first ASK cycle: timeout, correct_r=0, go to JUDGE. The first cycle is a grace cycle that masks stale timer output.
  - If ans_valid and time_left==0 occur in the same cycle, the answer wins and is judged normally, with t_r=0.
- JUDGE: 1 cycle.
  - Correct: score += 1 + t_r, saturating at 127; last_correct=1, last_timeout=0.
  - Wrong: score unchanged; last_correct=0, last_timeout=0.
  - Timeout: score unchanged; last_correct=0, last_timeout=1.
- FEEDBACK: hold for FB_CYCLES cycles, then:
  - If round_idx==NUM_ROUNDS-1, go to DONE.
  - Otherwise round_idx++ and go to FETCH.
- DONE: done=1. score and the last_* flags are held. start=1 clears as in IDLE and goes to FETCH.
- start is ignored outside IDLE and DONE. ans_valid is ignored outside ASK.
- timer_stop=1 in every state except ASK. timer_reset=1 only in ARM.

## Timing
- Reset (reset=0 at a clk edge):
  - state IDLE; prob_req 0, timer_reset 0, timer_stop 1.
  - score 0, round_idx 0, last_correct 0, last_timeout 0, done 0.
  - Reset mid-game abandons the round immediately; the next cycle is IDLE.
- All outputs are registered or decoded from the state register. No combinational input-to-output paths.
- Latencies:
  - start → prob_req high: 1 cycle.
  - prob_valid → timer_reset: 1 cycle.
  - ans_valid → score update visible: 2 cycles (JUDGE registers at its end).
  - JUDGE → FEEDBACK exit: FB_CYCLES cycles.
- prob_valid arriving in the same cycle prob_req first rises is accepted.
- Feedback counter: width is clog2(FB_CYCLES+1). It loads 0 on FEEDBACK entry and exits when it reaches FB_CYCLES-1.
- Score arithmetic: 8-bit intermediate sum, clamped to 127.

## Structure
- Package quiz_pkg holds:
  - the state enum qstate_t with the fixed encodings above;
  - constants SCORE_W=7, TIME_W=4, SCORE_MAX=127.
- One sub-module, quiz_scorer: registered saturating score accumulator with inputs clear, add_en and bonus[3:0], and output score. The FSM, feedback counter and capture registers remain in the top module.

## Test plan
- NUM_ROUNDS=2, FB_CYCLES=4:
  - Round 0: start; prob_expected=0x2A; ans_value=0x2A at time_left=6. Required: score=7, last_correct=1.
  - Round 1: no answer; time_left driven to 0. Required: last_timeout=1, score=7, done=1, state_o=6.
- Wrong answer 0x2B against 0x2A → score unchanged, last_correct=0, last_timeout=0, round_idx advances after 4 FEEDBACK cycles.
- ans_valid coincident with time_left=0 and correct value → judged correct, score +1, last_timeout=0. time_left=0 on the first ASK cycle with no answer → no timeout.
- Saturation: preload near max with correct answers at time_left=9 → score stops at 127, never wraps.
- reset=0 asserted during ASK → next cycle IDLE, timer_stop=1, score=0. start during ASK and ans_valid during FETCH → no effect.
